spi_reg_commit: RTL and testbench
=================================

SPI_REG_COMMIT -- requirements
Module: spi_reg_commit

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchroniser depth for wr_toggle; legal values are 2 to 4.
REQ-002 Parameter ERR_W, default 4, sets the width of the error counter.
REQ-003 Port iclk, input, 1, the internal clock and the only clock in the block.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port wr_toggle, input, 1, write strobe from the SPI input stage; it inverts once per completed write frame and is asynchronous to iclk.
REQ-006 Port wr_addr, input, 8, target register address (the mux control byte); it is stable from before each wr_toggle edge until wr_ack_toggle answers it.
REQ-007 Port wr_data, input, 8, write data byte; it has the same stability rule as wr_addr.
REQ-008 Port reg1, output, 8, configuration register.
REQ-009 Port reg2, output, 8, control register; bit0 is self-clearing.
REQ-010 Port reg3, output, 8, parameter register.
REQ-011 Port start_pulse, output, 1, one-cycle pulse issued on a commit of reg2 with bit0 = 1.
REQ-012 Port wr_ack_toggle, output, 1, inverts once per processed frame and returns to the SPI domain.
REQ-013 Port err_count, output, ERR_W, saturating count of rejected writes.
REQ-014 Port overrun, output, 1, sticky flag set when a frame is dropped.

Function
REQ-015 wr_toggle SHALL pass through SYNC_STAGES flops and then one history flop; each inequality between the synchronised value and its history SHALL form one edge event.
REQ-016 The FSM SHALL have three states: IDLE, CAPTURE and COMMIT.
- IDLE goes to CAPTURE on an edge event.
- CAPTURE goes to COMMIT unconditionally.
- COMMIT goes to IDLE unconditionally.
REQ-017 On entry to CAPTURE, wr_addr and wr_data SHALL be latched into internal registers.
REQ-018 All register updates and the wr_ack_toggle flip SHALL occur on the edge that leaves COMMIT.
REQ-019 With SYNC_STAGES=2, if wr_toggle changes before iclk edge N, the registers and wr_ack_toggle SHALL update at edge N+4.
REQ-020 Address decode SHALL be: 1 writes reg1, 2 writes reg2, 3 writes reg3.
REQ-021 Address 0 or any address of 4 or above SHALL leave all registers unchanged and SHALL increment err_count, which saturates at all-ones.
REQ-022 wr_ack_toggle SHALL flip for every processed frame, including rejected ones.
REQ-023 A write to reg2 with data bit0 = 1 SHALL store bit0 as 1, assert start_pulse in the following cycle, and clear reg2 bit0 one cycle after that; bits 7:1 SHALL be stored as written.
REQ-024 An edge event while the FSM is in CAPTURE or COMMIT SHALL set overrun and be discarded without acknowledgement.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Two wr_toggle edges that occur within one synchroniser window SHALL be treated as no event; the upstream protocol forbids this case.

Reset
REQ-027 rst SHALL asynchronously force all of the following: state IDLE, reg1=0x00, reg2=0x00, reg3=0xFF, start_pulse=0, wr_ack_toggle=0, err_count=0, overrun=0.
REQ-028 rst SHALL also clear the synchroniser and history flops to 0, so a frame in flight is lost and is not acknowledged.
REQ-029 On reset release, the first edge event SHALL be detected only after a genuine wr_toggle change.

Configuration
REQ-030 Macro SPI_WR_LOCK_EN SHALL be defined or not defined at compile time.
- Defined: while reg1 bit7 = 1, writes to reg2 and reg3 SHALL be rejected as in REQ-021, and reg1 itself SHALL remain writable.
- Not defined: reg1 bit7 SHALL be an ordinary storage bit, with no lock logic present.

Structure
REQ-031 A shared package spi_pkg SHALL hold:
- the FSM state enum;
- the constants ADDR_REG1=1, ADDR_REG2=2 and ADDR_REG3=3;
- the reset value constants;
- the constant START_BIT=0.
REQ-032 The synchroniser SHALL be a separate sub-module, toggle_sync, with the ports iclk, rst, d and q and parameter STAGES.

Verification
REQ-033 Reset, then toggle with addr=1, data=0x5A: reg1=0x5A at edge N+4 and wr_ack_toggle=1.
REQ-034 Toggle with addr=2, data=0x81: reg2=0x81, then start_pulse high for exactly one cycle, then reg2=0x80.
REQ-035 Toggle with addr=0 and then addr=9: registers unchanged, err_count=2, two acknowledgement flips; a further 14 rejected writes leave err_count=15.
REQ-036 A second toggle two cycles after the first: overrun=1, only the first frame is committed, only one acknowledgement flip.
REQ-037 With SPI_WR_LOCK_EN defined, write reg1=0x80 and then addr=3, data=0x11: reg3 stays 0xFF and err_count=1. Without the macro, the same sequence gives reg3=0x11.
REQ-038 Assert rst at edge N+2 of a write: all outputs return to their reset values and no acknowledgement flip occurs.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register commit block: FSM states,
// register addresses, reset values and control bit positions.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMMIT
  } state_t;

  localparam logic [7:0] ADDR_REG1 = 8'd1;
  localparam logic [7:0] ADDR_REG2 = 8'd2;
  localparam logic [7:0] ADDR_REG3 = 8'd3;

  localparam logic [7:0] REG1_RST = 8'h00;
  localparam logic [7:0] REG2_RST = 8'h00;
  localparam logic [7:0] REG3_RST = 8'hFF;

  localparam int unsigned START_BIT = 0;
  localparam int unsigned LOCK_BIT  = 7;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser that brings the asynchronous write toggle into iclk.
module toggle_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic iclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_reg_commit.sv
// Commits SPI write frames (toggle handshake) into reg1..reg3 in the iclk domain.
// Optional macro SPI_WR_LOCK_EN: reg1 bit7 write-protects reg2 and reg3.
module spi_reg_commit
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             wr_toggle,
  input  logic [7:0]       wr_addr,
  input  logic [7:0]       wr_data,
  output logic [7:0]       reg1,
  output logic [7:0]       reg2,
  output logic [7:0]       reg3,
  output logic             start_pulse,
  output logic             wr_ack_toggle,
  output logic [ERR_W-1:0] err_count,
  output logic             overrun
);

  localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES + 1);

  state_t     state;
  logic       tog_sync;
  logic       tog_hist;
  logic [2:0] prime_cnt;
  logic       armed;
  logic       edge_evt;
  logic [7:0] cap_addr;
  logic [7:0] cap_data;
  logic       start_pend;
  logic       accept;

  toggle_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .iclk(iclk),
    .rst (rst),
    .d   (wr_toggle),
    .q   (tog_sync)
  );

  // Events are masked until the synchroniser has refilled after reset, so a
  // toggle level left high by the SPI side is not mistaken for a new frame.
  assign armed    = (prime_cnt == PRIME_LAST);
  assign edge_evt = armed && (tog_sync != tog_hist);

  always_comb begin
    accept = 1'b0;
    if (cap_addr == ADDR_REG1) begin
      accept = 1'b1;
    end else if (cap_addr == ADDR_REG2 || cap_addr == ADDR_REG3) begin
`ifdef SPI_WR_LOCK_EN
      accept = !reg1[LOCK_BIT];
`else
      accept = 1'b1;
`endif
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tog_hist      <= 1'b0;
      prime_cnt     <= '0;
      cap_addr      <= '0;
      cap_data      <= '0;
      start_pend    <= 1'b0;
      reg1          <= REG1_RST;
      reg2          <= REG2_RST;
      reg3          <= REG3_RST;
      start_pulse   <= 1'b0;
      wr_ack_toggle <= 1'b0;
      err_count     <= '0;
      overrun       <= 1'b0;
    end else begin
      tog_hist <= tog_sync;
      if (!armed) prime_cnt <= prime_cnt + 3'd1;

      start_pulse <= start_pend;
      start_pend  <= 1'b0;
      if (start_pulse) reg2[START_BIT] <= 1'b0;

      case (state)
        IDLE: begin
          if (edge_evt) begin
            state    <= CAPTURE;
            cap_addr <= wr_addr;
            cap_data <= wr_data;
          end
        end
        CAPTURE: begin
          if (edge_evt) overrun <= 1'b1;
          state <= COMMIT;
        end
        COMMIT: begin
          if (edge_evt) overrun <= 1'b1;
          state         <= IDLE;
          wr_ack_toggle <= ~wr_ack_toggle;
          if (accept) begin
            if (cap_addr == ADDR_REG1) reg1 <= cap_data;
            if (cap_addr == ADDR_REG3) reg3 <= cap_data;
            if (cap_addr == ADDR_REG2) begin
              reg2       <= cap_data;
              start_pend <= cap_data[START_BIT];
            end
          end else if (err_count != '1) begin
            err_count <= err_count + ERR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_commit.sv
// Directed self-checking bench for spi_reg_commit (default SYNC_STAGES=2, ERR_W=4).
module tb_spi_reg_commit;

  logic       iclk;
  logic       rst;
  logic       wr_toggle;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] reg1, reg2, reg3;
  logic       start_pulse;
  logic       wr_ack_toggle;
  logic [3:0] err_count;
  logic       overrun;

  int unsigned tests_run;
  int unsigned tests_failed;
  logic        exp_ack;

  spi_reg_commit #(
    .SYNC_STAGES(2),
    .ERR_W      (4)
  ) dut (
    .iclk         (iclk),
    .rst          (rst),
    .wr_toggle    (wr_toggle),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .reg1         (reg1),
    .reg2         (reg2),
    .reg3         (reg3),
    .start_pulse  (start_pulse),
    .wr_ack_toggle(wr_ack_toggle),
    .err_count    (err_count),
    .overrun      (overrun)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_ack = 1'b0;
    repeat (6) tick();
  endtask

  // Launch a frame before edge N and return just after edge N+4.
  task automatic frame(input logic [7:0] a, input logic [7:0] d);
    wr_addr   = a;
    wr_data   = d;
    wr_toggle = ~wr_toggle;
    repeat (5) tick();
    exp_ack = ~exp_ack;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (reg1 !== 8'h00) begin tests_failed++; $display("FAIL rst_reg1: got %h want %h", reg1, 8'h00); end
    tests_run++; if (reg2 !== 8'h00) begin tests_failed++; $display("FAIL rst_reg2: got %h want %h", reg2, 8'h00); end
    tests_run++; if (reg3 !== 8'hFF) begin tests_failed++; $display("FAIL rst_reg3: got %h want %h", reg3, 8'hFF); end
    tests_run++; if ({start_pulse, wr_ack_toggle, overrun} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags: got %b want %b", {start_pulse, wr_ack_toggle, overrun}, 3'b000); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("FAIL rst_err: got %0d want %0d", err_count, 0); end
  endtask

  task automatic test_write_reg1();
    wr_addr   = 8'd1;
    wr_data   = 8'h5A;
    wr_toggle = ~wr_toggle;
    repeat (4) tick();
    tests_run++; if (reg1 !== 8'h00) begin tests_failed++; $display("FAIL reg1_early: got %h want %h", reg1, 8'h00); end
    tests_run++; if (wr_ack_toggle !== 1'b0) begin tests_failed++; $display("FAIL ack_early: got %b want %b", wr_ack_toggle, 1'b0); end
    tick();
    exp_ack = ~exp_ack;
    tests_run++; if (reg1 !== 8'h5A) begin tests_failed++; $display("FAIL reg1_commit: got %h want %h", reg1, 8'h5A); end
    tests_run++; if (wr_ack_toggle !== 1'b1) begin tests_failed++; $display("FAIL ack_reg1: got %b want %b", wr_ack_toggle, 1'b1); end
  endtask

  task automatic test_start_pulse();
    frame(8'd2, 8'h81);
    tests_run++; if (reg2 !== 8'h81) begin tests_failed++; $display("FAIL reg2_commit: got %h want %h", reg2, 8'h81); end
    tests_run++; if (start_pulse !== 1'b0) begin tests_failed++; $display("FAIL start_n4: got %b want %b", start_pulse, 1'b0); end
    tick();
    tests_run++; if (start_pulse !== 1'b1) begin tests_failed++; $display("FAIL start_n5: got %b want %b", start_pulse, 1'b1); end
    tests_run++; if (reg2 !== 8'h81) begin tests_failed++; $display("FAIL reg2_n5: got %h want %h", reg2, 8'h81); end
    tick();
    tests_run++; if (start_pulse !== 1'b0) begin tests_failed++; $display("FAIL start_n6: got %b want %b", start_pulse, 1'b0); end
    tests_run++; if (reg2 !== 8'h80) begin tests_failed++; $display("FAIL reg2_selfclear: got %h want %h", reg2, 8'h80); end
    tick();
    tests_run++; if (start_pulse !== 1'b0) begin tests_failed++; $display("FAIL start_n7: got %b want %b", start_pulse, 1'b0); end
  endtask

  task automatic test_reject();
    logic [7:0] bad_addr [14];
    bad_addr = '{8'd0, 8'd4, 8'd5, 8'd9, 8'd15, 8'd16, 8'd64, 8'd128,
                 8'd200, 8'd254, 8'd255, 8'd0, 8'd7, 8'd100};
    frame(8'd0, 8'h11);
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL ack_reject0: got %b want %b", wr_ack_toggle, exp_ack); end
    frame(8'd9, 8'h22);
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL ack_reject9: got %b want %b", wr_ack_toggle, exp_ack); end
    tests_run++; if (err_count !== 4'd2) begin tests_failed++; $display("FAIL err_two: got %0d want %0d", err_count, 2); end
    tests_run++; if ({reg1, reg2, reg3} !== {8'h5A, 8'h80, 8'hFF}) begin tests_failed++; $display("FAIL regs_unchanged: got %h want %h", {reg1, reg2, reg3}, {8'h5A, 8'h80, 8'hFF}); end
    for (int i = 0; i < 14; i++) frame(bad_addr[i], 8'hC3);
    tests_run++; if (err_count !== 4'd15) begin tests_failed++; $display("FAIL err_saturate: got %0d want %0d", err_count, 15); end
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL ack_after_rejects: got %b want %b", wr_ack_toggle, exp_ack); end
    tests_run++; if ({reg1, reg2, reg3} !== {8'h5A, 8'h80, 8'hFF}) begin tests_failed++; $display("FAIL regs_after_rejects: got %h want %h", {reg1, reg2, reg3}, {8'h5A, 8'h80, 8'hFF}); end
  endtask

  task automatic test_overrun();
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_pre: got %b want %b", overrun, 1'b0); end
    wr_addr   = 8'd3;
    wr_data   = 8'h42;
    wr_toggle = ~wr_toggle;
    tick();
    tick();
    wr_toggle = ~wr_toggle;
    repeat (3) tick();
    exp_ack = ~exp_ack;
    tests_run++; if (reg3 !== 8'h42) begin tests_failed++; $display("FAIL overrun_reg3: got %h want %h", reg3, 8'h42); end
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL overrun_ack: got %b want %b", wr_ack_toggle, exp_ack); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_set: got %b want %b", overrun, 1'b1); end
    repeat (8) tick();
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL overrun_no_second_ack: got %b want %b", wr_ack_toggle, exp_ack); end
    tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want %b", overrun, 1'b1); end
    tests_run++; if (err_count !== 4'd15) begin tests_failed++; $display("FAIL overrun_err: got %0d want %0d", err_count, 15); end
  endtask

  task automatic test_lock();
    logic [7:0] exp_reg3;
    logic [3:0] exp_err;
`ifdef SPI_WR_LOCK_EN
    exp_reg3 = 8'hFF;
    exp_err  = 4'd1;
`else
    exp_reg3 = 8'h11;
    exp_err  = 4'd0;
`endif
    apply_reset();
    tests_run++; if (wr_ack_toggle !== 1'b0) begin tests_failed++; $display("FAIL lock_ack_after_reset: got %b want %b", wr_ack_toggle, 1'b0); end
    frame(8'd1, 8'h80);
    tests_run++; if (reg1 !== 8'h80) begin tests_failed++; $display("FAIL lock_reg1: got %h want %h", reg1, 8'h80); end
    frame(8'd3, 8'h11);
    tests_run++; if (reg3 !== exp_reg3) begin tests_failed++; $display("FAIL lock_reg3: got %h want %h", reg3, exp_reg3); end
    tests_run++; if (err_count !== exp_err) begin tests_failed++; $display("FAIL lock_err: got %0d want %0d", err_count, exp_err); end
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL lock_ack: got %b want %b", wr_ack_toggle, exp_ack); end
    frame(8'd1, 8'h01);
    tests_run++; if (reg1 !== 8'h01) begin tests_failed++; $display("FAIL lock_reg1_writable: got %h want %h", reg1, 8'h01); end
  endtask

  task automatic test_reset_mid_frame();
    frame(8'd2, 8'h3C);
    wr_addr   = 8'd3;
    wr_data   = 8'h77;
    wr_toggle = ~wr_toggle;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    tests_run++; if ({reg1, reg2, reg3} !== {8'h00, 8'h00, 8'hFF}) begin tests_failed++; $display("FAIL midrst_regs: got %h want %h", {reg1, reg2, reg3}, {8'h00, 8'h00, 8'hFF}); end
    tests_run++; if ({start_pulse, wr_ack_toggle, overrun} !== 3'b000) begin tests_failed++; $display("FAIL midrst_flags: got %b want %b", {start_pulse, wr_ack_toggle, overrun}, 3'b000); end
    tick();
    tick();
    rst = 1'b0;
    exp_ack = 1'b0;
    repeat (10) tick();
    tests_run++; if (wr_ack_toggle !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_ack: got %b want %b", wr_ack_toggle, 1'b0); end
    tests_run++; if ({reg1, reg2, reg3} !== {8'h00, 8'h00, 8'hFF}) begin tests_failed++; $display("FAIL midrst_lost_frame: got %h want %h", {reg1, reg2, reg3}, {8'h00, 8'h00, 8'hFF}); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("FAIL midrst_err: got %0d want %0d", err_count, 0); end
    frame(8'd1, 8'hA5);
    tests_run++; if (reg1 !== 8'hA5) begin tests_failed++; $display("FAIL midrst_next_frame: got %h want %h", reg1, 8'hA5); end
    tests_run++; if (wr_ack_toggle !== exp_ack) begin tests_failed++; $display("FAIL midrst_next_ack: got %b want %b", wr_ack_toggle, exp_ack); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_ack      = 1'b0;
    rst          = 1'b1;
    wr_toggle    = 1'b0;
    wr_addr      = 8'h00;
    wr_data      = 8'h00;

    test_reset();
    test_write_reg1();
    test_start_pulse();
    test_reject();
    test_overrun();
    test_lock();
    test_reset_mid_frame();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
